// File: rtl/cplx_pkg.sv
// Shared constants and tag type for the complex multiplier and its arbiter.
// No logic; widths here must agree with the cplx_mult instance.
package cplx_pkg;
  localparam int CPLX_IN_W     = 18;
  localparam int CPLX_OUT_W    = 48;
  localparam int CPLX_MULT_LAT = 4;
  localparam int TAG_IDX_W     = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;
endpackage

// File: rtl/cplx_mult_arbiter_if.sv
// Requester-side bus of the shared multiplier: per-requester operands/handshake, broadcast results.
// master = requester side, slave = arbiter side.
interface cplx_mult_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
);
  import cplx_pkg::*;

  logic [NREQ-1:0]           i_req_valid;
  logic [NREQ-1:0]           o_req_ready;
  logic [CPLX_IN_W*NREQ-1:0] i_s18_AR;
  logic [CPLX_IN_W*NREQ-1:0] i_s18_AI;
  logic [CPLX_IN_W*NREQ-1:0] i_s18_BR;
  logic [CPLX_IN_W*NREQ-1:0] i_s18_BI;
  logic [NREQ-1:0]           o_res_valid;
  logic [CPLX_OUT_W-1:0]     o_s48_R;
  logic [CPLX_OUT_W-1:0]     o_s48_I;
  logic [IDX_W+1:0]          o_inflight;
  logic                      o_err;

  modport master (
    output i_req_valid, i_s18_AR, i_s18_AI, i_s18_BR, i_s18_BI,
    input  o_req_ready, o_res_valid, o_s48_R, o_s48_I, o_inflight, o_err
  );

  modport slave (
    input  i_req_valid, i_s18_AR, i_s18_AI, i_s18_BR, i_s18_BI,
    output o_req_ready, o_res_valid, o_s48_R, o_s48_I, o_inflight, o_err
  );
endinterface

// File: rtl/cplx_mult.sv
// 18x18 signed complex multiplier, full-precision 48-bit results, 4-cycle latency.
// Fully pipelined, accepts one operand set every cycle, no backpressure.
module cplx_mult
  import cplx_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_u1_valid_in,
  input  logic signed [CPLX_IN_W-1:0]  i_s18_AR,
  input  logic signed [CPLX_IN_W-1:0]  i_s18_AI,
  input  logic signed [CPLX_IN_W-1:0]  i_s18_BR,
  input  logic signed [CPLX_IN_W-1:0]  i_s18_BI,
  output logic                         o_u1_valid_out,
  output logic signed [CPLX_OUT_W-1:0] o_s48_R,
  output logic signed [CPLX_OUT_W-1:0] o_s48_I
);
  localparam int PW = 2 * CPLX_IN_W;

  logic signed [CPLX_IN_W-1:0]  ar1, ai1, br1, bi1;
  logic signed [PW-1:0]         p_rr, p_ii, p_ri, p_ir;
  logic signed [CPLX_OUT_W-1:0] s_r, s_i;
  logic [2:0]                   vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ar1 <= '0; ai1 <= '0; br1 <= '0; bi1 <= '0;
      p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
      s_r <= '0; s_i <= '0;
      o_s48_R <= '0; o_s48_I <= '0;
      vld <= '0;
      o_u1_valid_out <= 1'b0;
    end else begin
      ar1 <= i_s18_AR; ai1 <= i_s18_AI; br1 <= i_s18_BR; bi1 <= i_s18_BI;
      p_rr <= ar1 * br1;
      p_ii <= ai1 * bi1;
      p_ri <= ar1 * bi1;
      p_ir <= ai1 * br1;
      // Sign-extend products before the add so the 48-bit sums cannot overflow.
      s_r <= CPLX_OUT_W'(p_rr) - CPLX_OUT_W'(p_ii);
      s_i <= CPLX_OUT_W'(p_ri) + CPLX_OUT_W'(p_ir);
      o_s48_R <= s_r;
      o_s48_I <= s_i;
      vld <= {vld[1:0], i_u1_valid_in};
      o_u1_valid_out <= vld[2];
    end
  end
endmodule

// File: rtl/cplx_mult_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching from pointer+1, 0 cycles.
// Pointer advances to the granted index only when upd is high.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          upd,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic [IW:0]   pos;
  logic          found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 1; i <= N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found               = 1'b1;
        gnt[pos[IW-1:0]]    = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr <= IW'(N-1);
    else if (upd) ptr <= idx;
  end
endmodule

// File: rtl/cplx_mult_arbiter.sv
// Shares one cplx_mult among NREQ requesters; result pulses MULT_LAT+1 cycles after issue.
// One issue per cycle via round-robin ready; results cannot be backpressured.
module cplx_mult_arbiter
  import cplx_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MULT_LAT = 4,
  parameter int IDX_W    = 2
) (
  input  logic               clk,
  input  logic               rst,
  cplx_mult_arbiter_if.slave bus
);
  logic [NREQ-1:0]              gnt;
  logic [NREQ-1:0]              ready;
  logic [IDX_W-1:0]             gnt_idx;
  logic                         issue;
  logic signed [CPLX_IN_W-1:0]  m_ar, m_ai, m_br, m_bi;
  logic                         mult_vld;
  logic signed [CPLX_OUT_W-1:0] mult_r, mult_i;
  tag_t                         tag_sr [MULT_LAT];
  tag_t                         tag_out;
  logic [NREQ-1:0]              res_valid;
  logic [CPLX_OUT_W-1:0]        res_r, res_i;
  logic [IDX_W+1:0]             inflight;
  logic                         err;

  rr_arbiter #(.N(NREQ), .IW(IDX_W)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (bus.i_req_valid),
    .upd (issue),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  // Grant is combinational, so hold it off while reset is asserted.
  assign ready           = gnt & {NREQ{~rst}};
  assign issue           = |ready;
  assign bus.o_req_ready = ready;

  assign m_ar = bus.i_s18_AR[CPLX_IN_W*gnt_idx +: CPLX_IN_W];
  assign m_ai = bus.i_s18_AI[CPLX_IN_W*gnt_idx +: CPLX_IN_W];
  assign m_br = bus.i_s18_BR[CPLX_IN_W*gnt_idx +: CPLX_IN_W];
  assign m_bi = bus.i_s18_BI[CPLX_IN_W*gnt_idx +: CPLX_IN_W];

  cplx_mult u_mult (
    .clk            (clk),
    .rst_n          (~rst),
    .i_u1_valid_in  (issue),
    .i_s18_AR       (m_ar),
    .i_s18_AI       (m_ai),
    .i_s18_BR       (m_br),
    .i_s18_BI       (m_bi),
    .o_u1_valid_out (mult_vld),
    .o_s48_R        (mult_r),
    .o_s48_I        (mult_i)
  );

  assign tag_out = tag_sr[MULT_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MULT_LAT; i++) tag_sr[i] <= '0;
    end else begin
      tag_sr[0] <= '{valid: issue, idx: TAG_IDX_W'(gnt_idx)};
      for (int i = 1; i < MULT_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= '0;
      res_r     <= '0;
      res_i     <= '0;
      inflight  <= '0;
      err       <= 1'b0;
    end else begin
      res_valid <= tag_out.valid ? (NREQ'(1) << tag_out.idx) : '0;
      if (tag_out.valid) begin
        res_r <= mult_r;
        res_i <= mult_i;
      end
      case ({issue, tag_out.valid})
        2'b10:   inflight <= inflight + (IDX_W+2)'(1);
        2'b01:   inflight <= inflight - (IDX_W+2)'(1);
        default: inflight <= inflight;
      endcase
      if (mult_vld != tag_out.valid) err <= 1'b1;
    end
  end

  assign bus.o_res_valid = res_valid;
  assign bus.o_s48_R     = res_r;
  assign bus.o_s48_I     = res_i;
  assign bus.o_inflight  = inflight;
  assign bus.o_err       = err;
endmodule

// File: tb/tb_cplx_mult_arbiter.sv
// Directed bench for cplx_mult_arbiter: reset, single/back-to-back issue, fairness,
// sparse contention, mid-flight reset and the sticky error flag.
module tb_cplx_mult_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  cplx_mult_arbiter_if #(.NREQ(4), .IDX_W(2)) bus ();

  cplx_mult_arbiter #(.NREQ(4), .MULT_LAT(4), .IDX_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [47:0] v);
    return {{16{v[47]}}, v};
  endfunction

  task automatic set_ops(input int k, input int ar, input int ai, input int br, input int bi);
    bus.i_s18_AR[18*k +: 18] = 18'(ar);
    bus.i_s18_AI[18*k +: 18] = 18'(ai);
    bus.i_s18_BR[18*k +: 18] = 18'(br);
    bus.i_s18_BI[18*k +: 18] = 18'(bi);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issued;
    int returned;
    int src;
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.i_req_valid = '0;
    bus.i_s18_AR = '0; bus.i_s18_AI = '0; bus.i_s18_BR = '0; bus.i_s18_BI = '0;

    #1;
    chk("rst_ready", 64'(bus.o_req_ready), 64'd0);
    chk("rst_res_valid", 64'(bus.o_res_valid), 64'd0);
    chk("rst_R", 64'(bus.o_s48_R), 64'd0);
    chk("rst_I", 64'(bus.o_s48_I), 64'd0);
    chk("rst_inflight", 64'(bus.o_inflight), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    bus.i_req_valid = 4'hF;
    #1;
    chk("rst_ready_with_valid", 64'(bus.o_req_ready), 64'd0);
    bus.i_req_valid = '0;
    tick(); tick();
    rst = 1'b0;

    // Fairness: requester k computes (k+1 + jk)(2 + 3j) -> R = 2-k, I = 5k+3.
    for (int k = 0; k < 4; k++) set_ops(k, k + 1, k, 2, 3);
    for (int c = 0; c < 16; c++) begin
      bus.i_req_valid = (c < 12) ? 4'hF : 4'h0;
      #1;
      if (c < 12) chk($sformatf("fair_grant_c%0d", c), 64'(bus.o_req_ready), 64'(4'b1 << (c % 4)));
      tick();
      issued   = (c + 1 < 12) ? c + 1 : 12;
      returned = (c - 3 < 0) ? 0 : ((c - 3 > 12) ? 12 : c - 3);
      chk($sformatf("fair_inflight_c%0d", c), 64'(bus.o_inflight), 64'(issued - returned));
      src = c - 4;
      if (src >= 0 && src < 12) begin
        chk($sformatf("fair_res_valid_c%0d", c), 64'(bus.o_res_valid), 64'(4'b1 << (src % 4)));
        chk($sformatf("fair_R_c%0d", c), sx(bus.o_s48_R), 64'(2 - (src % 4)));
        chk($sformatf("fair_I_c%0d", c), sx(bus.o_s48_I), 64'(5 * (src % 4) + 3));
      end else begin
        chk($sformatf("fair_res_idle_c%0d", c), 64'(bus.o_res_valid), 64'd0);
      end
    end

    // Single issue from requester 2.
    set_ops(2, -9830, 51118, -51511, 3696);
    bus.i_req_valid = 4'b0100;
    #1;
    chk("single_ready", 64'(bus.o_req_ready), 64'b0100);
    tick();
    bus.i_req_valid = '0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk($sformatf("single_res_valid_j%0d", j), 64'(bus.o_res_valid), (j == 4) ? 64'b0100 : 64'd0);
      if (j >= 4) begin
        chk($sformatf("single_R_j%0d", j), sx(bus.o_s48_R), 64'sd317421002);
        chk($sformatf("single_I_j%0d", j), sx(bus.o_s48_I), -64'sd2669470978);
      end
    end

    // Back-to-back from requester 0.
    set_ops(0, -4981, 19661, -3277, 4443);
    bus.i_req_valid = 4'b0001;
    #1;
    chk("b2b_ready0", 64'(bus.o_req_ready), 64'b0001);
    tick();
    set_ops(0, -9830, 51118, -51511, 3696);
    #1;
    chk("b2b_ready1", 64'(bus.o_req_ready), 64'b0001);
    tick();
    bus.i_req_valid = '0;
    for (int j = 2; j <= 6; j++) begin
      tick();
      chk($sformatf("b2b_res_valid_j%0d", j), 64'(bus.o_res_valid), (j == 4 || j == 5) ? 64'b0001 : 64'd0);
      if (j == 4) begin
        chk("b2b_R_first", sx(bus.o_s48_R), -64'sd71031086);
        chk("b2b_I_first", sx(bus.o_s48_I), -64'sd86559680);
      end
      if (j == 5) begin
        chk("b2b_R_second", sx(bus.o_s48_R), 64'sd317421002);
        chk("b2b_I_second", sx(bus.o_s48_I), -64'sd2669470978);
      end
    end

    // Sparse contention between requesters 1 and 3.
    set_ops(1, 100, 200, 3, 4);
    set_ops(3, 7, 0, 7, 0);
    bus.i_req_valid = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("sparse_grant_c%0d", c), 64'(bus.o_req_ready), (c % 2 == 0) ? 64'b0010 : 64'b1000);
      tick();
    end
    bus.i_req_valid = '0;
    repeat (6) tick();
    chk("sparse_drained", 64'(bus.o_inflight), 64'd0);
    chk("sparse_last_R", sx(bus.o_s48_R), 64'sd49);

    // Reset while three operations are in flight.
    bus.i_req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("midrst_grant_c%0d", c), 64'(bus.o_req_ready), 64'b0010);
      tick();
    end
    bus.i_req_valid = '0;
    tick();
    chk("midrst_inflight_before", 64'(bus.o_inflight), 64'd3);
    rst = 1'b1;
    #1;
    chk("midrst_res_valid", 64'(bus.o_res_valid), 64'd0);
    chk("midrst_R", 64'(bus.o_s48_R), 64'd0);
    chk("midrst_I", 64'(bus.o_s48_I), 64'd0);
    chk("midrst_inflight", 64'(bus.o_inflight), 64'd0);
    tick();
    rst = 1'b0;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("midrst_no_result_j%0d", j), 64'(bus.o_res_valid), 64'd0);
    end
    bus.i_req_valid = 4'hF;
    #1;
    chk("midrst_next_grant", 64'(bus.o_req_ready), 64'b0001);
    tick();
    bus.i_req_valid = '0;
    repeat (6) tick();
    chk("midrst_err_clear", 64'(bus.o_err), 64'd0);
    chk("midrst_inflight_end", 64'(bus.o_inflight), 64'd0);

    // Spurious multiplier valid with nothing in flight.
    force dut.mult_vld = 1'b1;
    tick();
    chk("err_set", 64'(bus.o_err), 64'd1);
    release dut.mult_vld;
    repeat (3) tick();
    chk("err_sticky", 64'(bus.o_err), 64'd1);
    chk("err_no_result", 64'(bus.o_res_valid), 64'd0);
    rst = 1'b1;
    #1;
    chk("err_cleared_by_rst", 64'(bus.o_err), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("err_stays_clear", 64'(bus.o_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cplx_mult_arbiter.md
Name: cplx_mult_arbiter

Overview:
- Shares one cplx_mult (18x18 signed complex multiplier, 48-bit results) among NREQ requesters, e.g. several FFT butterfly stages needing twiddle multiplies.
- Accepts at most one operand set per cycle using round-robin valid/ready arbitration.
- Tags each issue, tracks it through the multiplier latency, and returns the product to the originating requester with a one-hot result-valid.
- Instantiates cplx_mult internally, driving its rst_n from ~rst.

Parameters:
- NREQ, 4: number of requesters (2..8).
- MULT_LAT, 4: cplx_mult latency in cycles, i_u1_valid_in to o_u1_valid_out. Must match the instance.
- IDX_W, 2: clog2(NREQ), width of grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- i_req_valid  in  NREQ  per-requester operand valid.
- o_req_ready  out  NREQ  per-requester grant; one-hot or zero.
- i_s18_AR  in  18*NREQ  flattened A real, requester k at [18k+17:18k].
- i_s18_AI  in  18*NREQ  flattened A imag.
- i_s18_BR  in  18*NREQ  flattened B real.
- i_s18_BI  in  18*NREQ  flattened B imag.
- o_res_valid  out  NREQ  one-hot result valid for owning requester.
- o_s48_R  out  48  product real, broadcast.
- o_s48_I  out  48  product imag, broadcast.
- o_inflight  out  IDX_W+2  number of issued, not yet returned operations.
- o_err  out  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (async):
  - o_req_ready=0, o_res_valid=0, o_s48_R/I=0, o_inflight=0, o_err=0.
  - Tag pipeline cleared; RR pointer = NREQ-1, so requester 0 wins first.
  - The multiplier is reset via rst_n=~rst.
- Arbitration is combinational from registered pointer and i_req_valid:
  - Search from pointer+1 modulo NREQ; the first valid requester gets o_req_ready.
  - No valid requester: o_req_ready=0, no issue.
- Handshake: transfer when i_req_valid[k] & o_req_ready[k].
  - Requester holds valid and operands stable until ready.
  - Valid must not drop before the transfer.
- Issue cycle:
  - Operands of the granted requester are muxed to the cplx_mult inputs with i_u1_valid_in=1.
  - {valid, IDX} is pushed into a MULT_LAT-deep tag shift register.
  - The pointer updates to the granted index on the next edge.
  - Back-to-back issue is allowed every cycle, from the same or a different requester.
- Round-robin fairness: with all NREQ requesters continuously valid, grants follow 0,1,2,3,0,... Each requester waits at most NREQ-1 cycles.
- Return path:
  - When the tag stage MULT_LAT-1 is valid, o_res_valid[tag] and o_s48_R/I are registered from the multiplier outputs.
  - Result appears MULT_LAT+1 cycles after the issue edge; o_res_valid is a 1-cycle pulse.
  - o_s48_R/I hold their last value when no result is valid.
- No backpressure on results: requesters must accept on the pulse cycle.
- o_inflight:
  - +1 on issue, -1 on return; both on the same cycle leaves it unchanged.
  - Max value is MULT_LAT; never wraps.
- o_err:
  - Set when o_u1_valid_out differs from the tag pipeline output valid.
  - Sticky until reset; the result is still routed per tag.
- Arithmetic:
  - R = AR*BR - AI*BI, I = AR*BI + AI*BR, signed, full precision, no rounding or saturation.
  - Full precision comes from cplx_mult; this block only routes.
- Reset mid-operation: in-flight results are discarded, with no o_res_valid after reset deassertion until new issues complete.
- Simultaneous issue and return in the same cycle is legal and independent.

Decomposition:
- Shared package (cplx_pkg):
  - Constants CPLX_IN_W=18, CPLX_OUT_W=48, CPLX_MULT_LAT=4.
  - Tag struct {valid, idx}.
- One sub-module: rr_arbiter (parameter N), which contains:
  - Request vector and registered pointer.
  - Outputs: one-hot grant and index.
  - Pointer-update enable.
- cplx_mult is instantiated as is.

Test Plan:
- Single issue: requester 2 presents AR=-9830, AI=51118, BR=-51511, BI=3696 -> o_req_ready[2] same cycle. MULT_LAT+1 cycles later o_res_valid=4'b0100, o_s48_R=317421002, o_s48_I=-2669470978.
- Back-to-back: requester 0 issues (-4981,19661,-3277,4443) then (-9830,51118,-51511,3696) on consecutive cycles -> two consecutive pulses on o_res_valid[0]:
  - first R=-71031086, I=-86559680;
  - then R=317421002, I=-2669470978.
- Fairness: all four valid for 12 cycles -> grant order 0,1,2,3 repeated 3 times; o_inflight saturates at 4; results return in issue order with matching one-hot tags.
- Sparse contention: only requesters 1 and 3 valid -> grants alternate 1,3,1,3; requesters 0 and 2 never ready.
- Reset mid-flight: 3 issues, then rst for 1 cycle two cycles later -> all outputs 0, o_inflight=0, no o_res_valid afterwards; next grant goes to requester 0.
- Error flag: force o_u1_valid_out high with no tag in flight -> o_err=1 next cycle and stays 1 until rst.
